// File: rtl/dpi_flow_ctx_sched_pkg.sv
// Shared types for the DPI flow-context scheduler.
// Holds the FSM state encoding and the default widths.
package dpi_flow_ctx_sched_pkg;

  localparam int FLOW_W_DEF  = 6;
  localparam int STATE_W_DEF = 11;
  localparam int OFF_W_DEF   = 16;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_SAVE   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/dpi_flow_ctx_ram.sv
// Per-flow DFA context table: async read, sync write.
// Ports: clk, rst (async clear of valid bits), we/waddr/wdata, raddr -> rdata/rvalid.
module dpi_flow_ctx_ram #(
  parameter int FLOW_W  = 6,
  parameter int STATE_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [FLOW_W-1:0]  waddr,
  input  logic [STATE_W-1:0] wdata,
  input  logic [FLOW_W-1:0]  raddr,
  output logic [STATE_W-1:0] rdata,
  output logic               rvalid
);

  localparam int DEPTH = 2 ** FLOW_W;

  logic [STATE_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   valid;

  // Contents are not reset; the valid vector masks stale entries.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= '0;
    else if (we) valid[waddr] <= 1'b1;
  end

  assign rdata  = mem[raddr];
  assign rvalid = valid[raddr];

endmodule

// File: rtl/dpi_flow_ctx_sched.sv
// Flow-context scheduler feeding a regex DFA engine: restores/saves per-flow
// DFA state around each packet and registers engine accepts as match reports.
// Ports: in_* byte stream (valid/ready), eng_* engine side, match_* reports,
// proto_err framing pulse, match_cnt (live only with DPI_FLOW_MATCH_CNT_EN).
module dpi_flow_ctx_sched
  import dpi_flow_ctx_sched_pkg::*;
#(
  parameter int FLOW_W  = FLOW_W_DEF,
  parameter int STATE_W = STATE_W_DEF,
  parameter int OFF_W   = OFF_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [7:0]         in_data,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [FLOW_W-1:0]  in_flow,
  input  logic               in_flow_new,
  output logic [7:0]         eng_char,
  output logic               eng_char_vld,
  output logic [STATE_W-1:0] eng_state,
  output logic               eng_state_vld,
  input  logic [STATE_W-1:0] eng_state_out,
  input  logic               eng_accept,
  output logic               match_vld,
  output logic [FLOW_W-1:0]  match_flow,
  output logic [OFF_W-1:0]   match_off,
  output logic               match_eop,
  output logic               proto_err,
  output logic [CNT_W-1:0]   match_cnt
);

  sched_state_t       state, state_nxt;
  logic [FLOW_W-1:0]  cur_flow;
  logic               new_flag;
  logic               first;
  logic [OFF_W-1:0]   off;
  logic [STATE_W-1:0] ctx_state;
  logic               ctx_valid;
  logic               acc;
  logic               hit;

  dpi_flow_ctx_ram #(
    .FLOW_W  (FLOW_W),
    .STATE_W (STATE_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (state == S_SAVE),
    .waddr  (cur_flow),
    .wdata  (eng_state_out),
    .raddr  (cur_flow),
    .rdata  (ctx_state),
    .rvalid (ctx_valid)
  );

  assign acc = (state == S_STREAM) && in_vld;
  assign hit = acc && eng_accept;

  always_comb begin
    state_nxt     = state;
    in_rdy        = 1'b0;
    proto_err     = 1'b0;
    eng_char      = '0;
    eng_char_vld  = 1'b0;
    eng_state     = '0;
    eng_state_vld = 1'b0;
    unique case (state)
      S_IDLE: begin
        // The sop beat is held and re-presented once context is loaded.
        in_rdy = !(in_vld && in_sop);
        if (in_vld && in_sop) state_nxt = S_LOAD;
        else if (in_vld)      proto_err = 1'b1;
      end
      S_LOAD: begin
        eng_state_vld = 1'b1;
        if (!new_flag && ctx_valid) eng_state = ctx_state;
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        in_rdy       = 1'b1;
        eng_char     = in_data;
        eng_char_vld = in_vld;
        proto_err    = in_vld && in_sop && !first;
        if (in_vld && in_eop) state_nxt = S_SAVE;
      end
      S_SAVE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Keep every output quiet while reset is held.
    if (rst) begin
      in_rdy    = 1'b0;
      proto_err = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_flow   <= '0;
      new_flag   <= 1'b0;
      first      <= 1'b0;
      off        <= '0;
      match_vld  <= 1'b0;
      match_flow <= '0;
      match_off  <= '0;
      match_eop  <= 1'b0;
    end else begin
      state     <= state_nxt;
      match_vld <= hit;
      if (state == S_IDLE && in_vld && in_sop) begin
        cur_flow <= in_flow;
        new_flag <= in_flow_new;
      end
      if (state == S_LOAD) begin
        off   <= '0;
        first <= 1'b1;
      end
      if (acc) begin
        first <= 1'b0;
        if (off != '1) off <= off + 1'b1;
      end
      if (hit) begin
        match_flow <= cur_flow;
        match_off  <= off;
        match_eop  <= in_eop;
      end
    end
  end

`ifdef DPI_FLOW_MATCH_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) match_cnt <= '0;
    else if (match_vld && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
  end
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_dpi_flow_ctx_sched.sv
// Directed bench for dpi_flow_ctx_sched with a behavioural "* OK" DFA engine.
// Checks context save/restore, new-flow reset, interleaving, framing, reset, counter.
module tb_dpi_flow_ctx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  in_data;
  logic        in_sop;
  logic        in_eop;
  logic [5:0]  in_flow;
  logic        in_flow_new;
  logic [7:0]  eng_char;
  logic        eng_char_vld;
  logic [10:0] eng_state;
  logic        eng_state_vld;
  logic [10:0] eng_state_out;
  logic        eng_accept;
  logic        match_vld;
  logic [5:0]  match_flow;
  logic [15:0] match_off;
  logic        match_eop;
  logic        proto_err;
  logic [15:0] match_cnt;

  int n_asrt = 0;
  int n_fail = 0;
  int overlap = 0;
  int exp_m = 0;

  int          p_nm;
  logic [10:0] p_ld;
  logic        p_perr;
  logic [15:0] p_moff;
  logic        p_meop;
  logic [5:0]  p_mflow;

  logic [10:0] ld;
  logic        pe;
  logic        cv;

  always #5 clk = ~clk;

  dpi_flow_ctx_sched dut (
    .clk           (clk),
    .rst           (rst),
    .in_vld        (in_vld),
    .in_rdy        (in_rdy),
    .in_data       (in_data),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_flow       (in_flow),
    .in_flow_new   (in_flow_new),
    .eng_char      (eng_char),
    .eng_char_vld  (eng_char_vld),
    .eng_state     (eng_state),
    .eng_state_vld (eng_state_vld),
    .eng_state_out (eng_state_out),
    .eng_accept    (eng_accept),
    .match_vld     (match_vld),
    .match_flow    (match_flow),
    .match_off     (match_off),
    .match_eop     (match_eop),
    .proto_err     (proto_err),
    .match_cnt     (match_cnt)
  );

  // Engine model: prefix automaton for "* OK", state 4 = just accepted.
  logic [10:0] est = '0;

  function automatic logic [10:0] dfa(input logic [10:0] s, input logic [7:0] c);
    logic [10:0] b;
    logic [7:0]  want;
    b = (s >= 11'd4) ? 11'd0 : s;
    case (b)
      11'd0:   want = "*";
      11'd1:   want = " ";
      11'd2:   want = "O";
      default: want = "K";
    endcase
    if (c == want)     return b + 11'd1;
    else if (c == "*") return 11'd1;
    else               return 11'd0;
  endfunction

  assign eng_state_out = est;
  assign eng_accept    = eng_char_vld && (dfa(est, eng_char) == 11'd4);

  always @(posedge clk) begin
    if (eng_state_vld)     est <= eng_state;
    else if (eng_char_vld) est <= dfa(est, eng_char);
  end

  always @(negedge clk) begin
    if (eng_state_vld && eng_char_vld) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One beat; waits (bounded) for acceptance, reports load state, proto_err, char_vld.
  task automatic beat(input logic [7:0] d, input logic sop, input logic eop,
                      input logic [5:0] fl, input logic nw,
                      output logic [10:0] lds, output logic perr, output logic cvl);
    logic ok;
    ok = 1'b0;
    lds = '0;
    perr = 1'b0;
    cvl = 1'b0;
    in_vld = 1'b1;
    in_data = d;
    in_sop = sop;
    in_eop = eop;
    in_flow = fl;
    in_flow_new = nw;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (eng_state_vld) lds = eng_state;
      if (in_rdy) begin
        ok = 1'b1;
        perr = proto_err;
        cvl = eng_char_vld;
      end
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    chk("handshake", {31'd0, ok}, 32'd1);
  endtask

  task automatic pkt(input string s, input logic [5:0] fl, input logic nw);
    logic [10:0] l;
    logic        e;
    logic        c;
    p_nm = 0;
    p_ld = '0;
    p_perr = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      beat(s[i], i == 0, i == s.len() - 1, fl, nw, l, e, c);
      if (i == 0) p_ld = l;
      p_perr = p_perr | e;
      if (match_vld) begin
        p_nm++;
        p_moff = match_off;
        p_meop = match_eop;
        p_mflow = match_flow;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_vld = 1'b0;
    in_data = '0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    in_flow = '0;
    in_flow_new = 1'b0;
    #12;
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
    chk("rst_match_vld", {31'd0, match_vld}, 32'd0);
    chk("rst_state_vld", {31'd0, eng_state_vld}, 32'd0);
    chk("rst_match_cnt", {16'd0, match_cnt}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("idle_in_rdy", {31'd0, in_rdy}, 32'd1);

    // 1: split match across two packets of flow 3
    pkt("* O", 6'd3, 1'b1);
    chk("t1a_ld", {21'd0, p_ld}, 32'd0);
    chk("t1a_nm", p_nm, 32'd0);
    pkt("K", 6'd3, 1'b0);
    exp_m++;
    chk("t1b_ld", {21'd0, p_ld}, 32'd3);
    chk("t1b_nm", p_nm, 32'd1);
    chk("t1b_flow", {26'd0, p_mflow}, 32'd3);
    chk("t1b_off", {16'd0, p_moff}, 32'd0);
    chk("t1b_eop", {31'd0, p_meop}, 32'd1);

    // 2: second packet restarts the flow
    pkt("* O", 6'd3, 1'b1);
    pkt("K", 6'd3, 1'b1);
    chk("t2_ld", {21'd0, p_ld}, 32'd0);
    chk("t2_nm", p_nm, 32'd0);

    // 3: interleaved flows keep separate contexts
    pkt("* O", 6'd1, 1'b1);
    pkt("* O", 6'd2, 1'b1);
    pkt("K", 6'd1, 1'b0);
    exp_m++;
    chk("t3a_nm", p_nm, 32'd1);
    chk("t3a_flow", {26'd0, p_mflow}, 32'd1);
    pkt("x", 6'd2, 1'b0);
    chk("t3b_ld", {21'd0, p_ld}, 32'd3);
    chk("t3b_nm", p_nm, 32'd0);

    // 4: framing violations
    beat("z", 1'b0, 1'b0, 6'd4, 1'b0, ld, pe, cv);
    chk("t4_idle_perr", {31'd0, pe}, 32'd1);
    chk("t4_idle_cv", {31'd0, cv}, 32'd0);
    beat("a", 1'b1, 1'b0, 6'd4, 1'b1, ld, pe, cv);
    chk("t4_first_perr", {31'd0, pe}, 32'd0);
    beat("S", 1'b1, 1'b0, 6'd4, 1'b1, ld, pe, cv);
    chk("t4_mid_perr", {31'd0, pe}, 32'd1);
    chk("t4_mid_cv", {31'd0, cv}, 32'd1);
    beat("c", 1'b0, 1'b1, 6'd4, 1'b0, ld, pe, cv);
    chk("t4_last_perr", {31'd0, pe}, 32'd0);

    // 5: reset mid-packet drops context
    pkt("* O", 6'd5, 1'b1);
    beat("x", 1'b1, 1'b0, 6'd5, 1'b0, ld, pe, cv);
    chk("t5_pre_ld", {21'd0, ld}, 32'd3);
    in_vld = 1'b1;
    in_sop = 1'b0;
    in_data = "q";
    rst = 1'b1;
    #1;
    chk("t5_rst_rdy", {31'd0, in_rdy}, 32'd0);
    chk("t5_rst_cv", {31'd0, eng_char_vld}, 32'd0);
    chk("t5_rst_char", {24'd0, eng_char}, 32'd0);
    chk("t5_rst_perr", {31'd0, proto_err}, 32'd0);
    chk("t5_rst_cnt", {16'd0, match_cnt}, 32'd0);
    exp_m = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_vld = 1'b0;
    beat("y", 1'b0, 1'b1, 6'd5, 1'b0, ld, pe, cv);
    chk("t5_drop_perr", {31'd0, pe}, 32'd1);
    chk("t5_drop_cv", {31'd0, cv}, 32'd0);
    pkt("K", 6'd5, 1'b0);
    chk("t5_ld", {21'd0, p_ld}, 32'd0);
    chk("t5_nm", p_nm, 32'd0);

    // 6: three matches in one packet and the match counter
    pkt("* OK* OK* OK", 6'd7, 1'b1);
    exp_m += 3;
    chk("t6_nm", p_nm, 32'd3);
    chk("t6_flow", {26'd0, p_mflow}, 32'd7);
    chk("t6_off", {16'd0, p_moff}, 32'd11);
    chk("t6_eop", {31'd0, p_meop}, 32'd1);
    @(posedge clk);
    #1;
`ifdef DPI_FLOW_MATCH_CNT_EN
    chk("t6_cnt", {16'd0, match_cnt}, exp_m);
`else
    chk("t6_cnt", {16'd0, match_cnt}, 32'd0);
`endif
    chk("no_overlap", overlap, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
